// File: rtl/osc_phase_sweep.sv
// Phase sweep for the oscillator slots.
// Each sample tick walks the slot index through every voice/oscillator/oe
// combination. The pitch stage answers a fixed number of cycles later, and
// that answer is added to a 32-bit phase register kept for each {voice, osc}
// slot. A note_on resets the phases of its voice at the next visit (key sync).
module osc_phase_sweep #(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 4,
  parameter int V_WIDTH   = 3,
  parameter int O_WIDTH   = 2,
  parameter int OE_WIDTH  = 1,
  parameter int E_WIDTH   = O_WIDTH + OE_WIDTH,
  parameter int PITCH_LAT = 3
) (
  input  logic                         const_clk,
  input  logic                         reset_reg_N,
  input  logic                         sample_tick,
  input  logic                         note_on,
  input  logic [V_WIDTH-1:0]           cur_key_adr,
  input  logic [23:0]                  osc_pitch_val,
  output logic [V_WIDTH+E_WIDTH-1:0]   xxxx,
  output logic [31:0]                  phase_out,
  output logic [V_WIDTH+O_WIDTH-1:0]   phase_idx,
  output logic                         phase_valid,
  output logic                         sweep_busy,
  output logic                         sweep_done,
  output logic                         overrun
);

  localparam int IDX_W  = V_WIDTH + E_WIDTH;
  localparam int SLOT_W = V_WIDTH + O_WIDTH;
  localparam int SLOTS  = VOICES * V_OSC;
  localparam int DCNT_W = (PITCH_LAT > 1) ? $clog2(PITCH_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN
  } state_t;

  // Sweep sequencer
  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_xxxx;
  logic [IDX_W-1:0]      w_xxxx_nxt;
  logic [DCNT_W-1:0]     r_dcnt;
  logic [DCNT_W-1:0]     w_dcnt_nxt;
  logic                  w_busy;
  logic                  w_done;
  logic                  r_overrun;

  // Issued index delayed to line up with the returned pitch: {valid, index}
  logic [PITCH_LAT-1:0][IDX_W:0] r_dly;

  // Key sync
  logic                  r_note_meta;
  logic                  r_note_sync;
  logic                  r_note_prev;
  logic                  w_key_edge;
  logic [VOICES-1:0]     r_sync_flag;

  // Phase storage and output registers
  logic [31:0]           r_phase [SLOTS];
  logic [31:0]           r_phase_out;
  logic [SLOT_W-1:0]     r_phase_idx;
  logic                  r_phase_valid;

  // Capture-stage decode
  logic [IDX_W:0]        w_cap;
  logic                  w_cap_vld;
  logic [IDX_W-1:0]      w_cap_idx;
  logic [OE_WIDTH-1:0]   w_cap_oe;
  logic [SLOT_W-1:0]     w_cap_slot;
  logic [V_WIDTH-1:0]    w_cap_voice;
  logic [O_WIDTH-1:0]    w_cap_osc;
  logic                  w_cap_upd;
  logic [31:0]           w_sum;
  logic [31:0]           w_new_phase;

  // Sequencer state register
  always_ff @(posedge const_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_state <= ST_IDLE;
      r_xxxx  <= '0;
      r_dcnt  <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_xxxx  <= w_xxxx_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // Sequencer next-state: walk all indices, then wait out the pitch latency
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_xxxx_nxt  = r_xxxx;
    w_dcnt_nxt  = r_dcnt;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_xxxx_nxt = '0;
        w_dcnt_nxt = '0;
        if (sample_tick) w_state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        w_busy = 1'b1;
        if (r_xxxx == {IDX_W{1'b1}}) begin
          w_state_nxt = ST_DRAIN;
          w_xxxx_nxt  = '0;
          w_dcnt_nxt  = '0;
        end else begin
          w_xxxx_nxt = r_xxxx + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (r_dcnt == DCNT_W'(PITCH_LAT - 1)) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sticky flag for a tick that arrives while a sweep is still running
  always_ff @(posedge const_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_overrun <= 1'b0;
    end else if (sample_tick && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  // Delay the issued index so it arrives together with its pitch word
  always_ff @(posedge const_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_dly <= '0;
    end else begin
      r_dly[0] <= {(r_state == ST_SWEEP), r_xxxx};
      for (int i = 1; i < PITCH_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_cap       = r_dly[PITCH_LAT-1];
  assign w_cap_vld   = w_cap[IDX_W];
  assign w_cap_idx   = w_cap[IDX_W-1:0];
  assign w_cap_oe    = w_cap_idx[OE_WIDTH-1:0];
  assign w_cap_slot  = w_cap_idx[IDX_W-1:OE_WIDTH];
  assign w_cap_voice = w_cap_slot[SLOT_W-1:O_WIDTH];
  assign w_cap_osc   = w_cap_slot[O_WIDTH-1:0];
  assign w_cap_upd   = w_cap_vld && (w_cap_oe == '0);
  assign w_sum       = r_phase[w_cap_slot] + {8'h00, osc_pitch_val};
  assign w_new_phase = r_sync_flag[w_cap_voice] ? 32'h0 : w_sum;

  // Synchronise note_on into this clock domain and keep one previous sample
  always_ff @(posedge const_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_note_meta <= 1'b0;
      r_note_sync <= 1'b0;
      r_note_prev <= 1'b0;
    end else begin
      r_note_meta <= note_on;
      r_note_sync <= r_note_meta;
      r_note_prev <= r_note_sync;
    end
  end

  assign w_key_edge = r_note_sync & ~r_note_prev;

  // Per-voice key-sync flags: cleared after the voice's last oscillator,
  // but a fresh key event in that same cycle keeps the flag set
  always_ff @(posedge const_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_sync_flag <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (w_cap_upd && (w_cap_voice == V_WIDTH'(v)) &&
            (w_cap_osc == O_WIDTH'(V_OSC - 1))) begin
          r_sync_flag[v] <= 1'b0;
        end
        if (w_key_edge && (cur_key_adr == V_WIDTH'(v))) begin
          r_sync_flag[v] <= 1'b1;
        end
      end
    end
  end

  // Accumulate the captured pitch into the slot phase and publish the result
  always_ff @(posedge const_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      // NOTE: the phase array is reset explicitly because a key-sync-free
      // start from zero is part of the behaviour, which rules out RAM mapping.
      for (int s = 0; s < SLOTS; s++) begin
        r_phase[s] <= '0;
      end
      r_phase_out   <= '0;
      r_phase_idx   <= '0;
      r_phase_valid <= 1'b0;
    end else begin
      r_phase_valid <= 1'b0;
      if (w_cap_upd) begin
        r_phase[w_cap_slot] <= w_new_phase;
        r_phase_out         <= w_new_phase;
        r_phase_idx         <= w_cap_slot;
        r_phase_valid       <= 1'b1;
      end
    end
  end

  assign xxxx        = r_xxxx;
  assign phase_out   = r_phase_out;
  assign phase_idx   = r_phase_idx;
  assign phase_valid = r_phase_valid;
  assign sweep_busy  = w_busy;
  assign sweep_done  = w_done;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_osc_phase_sweep.sv
// Bench for osc_phase_sweep: a cycle model of the sweep sequencer, a pitch
// stage that answers the DUT's slot index after the pitch latency, and a
// scoreboard of expected phase words popped as phase_valid pulses appear.
module tb_osc_phase_sweep;

  localparam int PITCH_LAT = 3;
  localparam int SLOTS     = 32;

  logic        const_clk = 1'b0;
  logic        reset_reg_N;
  logic        sample_tick;
  logic        note_on;
  logic [2:0]  cur_key_adr;
  logic [23:0] osc_pitch_val;
  logic [5:0]  xxxx;
  logic [31:0] phase_out;
  logic [4:0]  phase_idx;
  logic        phase_valid;
  logic        sweep_busy;
  logic        sweep_done;
  logic        overrun;

  osc_phase_sweep dut (
    .const_clk     (const_clk),
    .reset_reg_N   (reset_reg_N),
    .sample_tick   (sample_tick),
    .note_on       (note_on),
    .cur_key_adr   (cur_key_adr),
    .osc_pitch_val (osc_pitch_val),
    .xxxx          (xxxx),
    .phase_out     (phase_out),
    .phase_idx     (phase_idx),
    .phase_valid   (phase_valid),
    .sweep_busy    (sweep_busy),
    .sweep_done    (sweep_done),
    .overrun       (overrun)
  );

  always #5 const_clk = ~const_clk;

  typedef struct {
    int          due;
    logic [4:0]  idx;
    logic [31:0] ph;
  } exp_t;

  typedef struct packed {
    logic       vld;
    logic [5:0] midx;
    logic [5:0] didx;
  } hist_t;

  exp_t        sb_q[$];
  hist_t       hist [4];

  int          n_cmp;
  int          n_mis;
  int          cyc;
  int          n_valid;
  int          n_done;
  int          first_busy_cyc;
  int          first_valid_cyc;

  // Sequencer model: 0 idle, 1 sweep, 2 drain
  int          m_state;
  logic [5:0]  m_idx;
  int          m_dcnt;
  logic        m_ovr;
  logic [31:0] m_phase [SLOTS];
  logic [7:0]  m_flag;
  logic [31:0] obs_phase [SLOTS];

  int          pitch_mode;
  logic [23:0] pitch_const;

  function automatic logic [23:0] pitch_of(input logic [5:0] ix);
    if (pitch_mode == 1) return {ix, 18'h0};
    return pitch_const;
  endfunction

  task automatic model_advance();
    case (m_state)
      0: begin
        m_idx = 6'd0;
        if (sample_tick) m_state = 1;
      end
      1: begin
        if (sample_tick) m_ovr = 1'b1;
        if (m_idx == 6'd63) begin
          m_state = 2;
          m_idx   = 6'd0;
          m_dcnt  = 0;
        end else begin
          m_idx = m_idx + 6'd1;
        end
      end
      default: begin
        if (sample_tick) m_ovr = 1'b1;
        if (m_dcnt == PITCH_LAT - 1) m_state = 0;
        else m_dcnt++;
      end
    endcase
  endtask

  // One clock: advance the model, compare at the falling edge, then play the
  // pitch stage and push the expected phase for the index it answers.
  task automatic step();
    logic        exp_done;
    logic [4:0]  slot;
    logic [2:0]  v;
    logic [31:0] nph;
    exp_t        e;
    @(posedge const_clk);
    if (reset_reg_N) model_advance();
    @(negedge const_clk);
    cyc++;
    sample_tick = 1'b0;

    exp_done = (m_state == 2) && (m_dcnt == PITCH_LAT - 1);
    n_cmp++;
    if (sweep_busy !== (m_state != 0)) begin
      n_mis++;
      $display("FAIL busy cyc=%0d: got %b expected %b", cyc, sweep_busy, (m_state != 0));
    end
    n_cmp++;
    if (sweep_done !== exp_done) begin
      n_mis++;
      $display("FAIL done cyc=%0d: got %b expected %b", cyc, sweep_done, exp_done);
    end
    n_cmp++;
    if (overrun !== m_ovr) begin
      n_mis++;
      $display("FAIL overrun cyc=%0d: got %b expected %b", cyc, overrun, m_ovr);
    end
    if (m_state != 2) begin
      n_cmp++;
      if (xxxx !== m_idx) begin
        n_mis++;
        $display("FAIL xxxx cyc=%0d: got %0d expected %0d", cyc, xxxx, m_idx);
      end
    end
    if (sweep_done === 1'b1) n_done++;
    if (sweep_busy === 1'b1 && first_busy_cyc < 0) first_busy_cyc = cyc;

    if (phase_valid === 1'b1) begin
      n_valid++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      obs_phase[phase_idx] = phase_out;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_valid cyc=%0d: got idx %0d phase %h, expected none", cyc, phase_idx, phase_out);
      end else begin
        e = sb_q.pop_front();
        if (e.due != cyc || e.idx !== phase_idx || e.ph !== phase_out) begin
          n_mis++;
          $display("FAIL phase cyc=%0d: got idx %0d phase %h, expected idx %0d phase %h due %0d",
                   cyc, phase_idx, phase_out, e.idx, e.ph, e.due);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      n_cmp++;
      n_mis++;
      $display("FAIL missing_valid cyc=%0d: got none, expected idx %0d phase %h", cyc, sb_q[0].idx, sb_q[0].ph);
      void'(sb_q.pop_front());
    end

    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{vld: (m_state == 1) && reset_reg_N, midx: m_idx, didx: xxxx};
    osc_pitch_val = pitch_of(hist[3].didx);
    if (hist[3].vld && hist[3].midx[0] == 1'b0) begin
      slot = hist[3].midx[5:1];
      v    = slot[4:2];
      nph  = m_flag[v] ? 32'h0 : m_phase[slot] + {8'h00, pitch_of(hist[3].midx)};
      m_phase[slot] = nph;
      if (slot[1:0] == 2'd3) m_flag[v] = 1'b0;
      sb_q.push_back('{due: cyc + 1, idx: slot, ph: nph});
    end
  endtask

  // Assert reset right now (caller sits just after a falling edge)
  task automatic do_reset();
    reset_reg_N = 1'b0;
    #1;
    n_cmp++;
    if ({xxxx, phase_out, phase_idx, phase_valid, sweep_busy, sweep_done, overrun} !== 48'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: got xxxx=%0d ph=%h idx=%0d v=%b busy=%b done=%b ovr=%b, expected all 0",
               xxxx, phase_out, phase_idx, phase_valid, sweep_busy, sweep_done, overrun);
    end
    m_state = 0;
    m_idx   = 6'd0;
    m_dcnt  = 0;
    m_ovr   = 1'b0;
    m_flag  = 8'h0;
    for (int s = 0; s < SLOTS; s++) begin
      m_phase[s]   = 32'h0;
      obs_phase[s] = 32'h0;
    end
    for (int i = 0; i < 4; i++) hist[i] = '0;
    sb_q.delete();
    repeat (2) step();
    reset_reg_N = 1'b1;
    repeat (2) step();
  endtask

  task automatic run_sweep(input int tick_at, input bit tick_last_drain);
    int k;
    n_valid     = 0;
    n_done      = 0;
    sample_tick = 1'b1;
    step();
    k = 1;
    while ((m_state != 0 || sb_q.size() > 0) && k < 200) begin
      if (k == tick_at) sample_tick = 1'b1;
      if (tick_last_drain && m_state == 2 && m_dcnt == PITCH_LAT - 1) sample_tick = 1'b1;
      step();
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_mis++;
      $display("FAIL sweep_timeout: got still busy after %0d cycles, expected idle", k);
    end
    repeat (3) step();
  endtask

  task automatic check_counts(input string name, input int exp_valid, input int exp_done);
    n_cmp++;
    if (n_valid != exp_valid) begin
      n_mis++;
      $display("FAIL %s_valid_count: got %0d expected %0d", name, n_valid, exp_valid);
    end
    n_cmp++;
    if (n_done != exp_done) begin
      n_mis++;
      $display("FAIL %s_done_count: got %0d expected %0d", name, n_done, exp_done);
    end
  endtask

  task automatic check_slot(input string name, input int s, input logic [31:0] exp_ph);
    n_cmp++;
    if (obs_phase[s] !== exp_ph) begin
      n_mis++;
      $display("FAIL %s slot %0d: got %h expected %h", name, s, obs_phase[s], exp_ph);
    end
  endtask

  task automatic test_reset();
    reset_reg_N = 1'b1;
    repeat (2) @(negedge const_clk);
    do_reset();
  endtask

  task automatic test_basic();
    logic [31:0] exp_ph;
    do_reset();
    pitch_mode  = 0;
    pitch_const = 24'h000100;
    for (int sw = 1; sw <= 3; sw++) begin
      run_sweep(-1, 1'b0);
      check_counts("basic", 32, 1);
      exp_ph = 32'h100 * sw;
      for (int s = 0; s < SLOTS; s++) check_slot("basic", s, exp_ph);
      repeat (29) step();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    pitch_mode  = 0;
    pitch_const = 24'hFFFFFF;
    for (int sw = 0; sw < 300; sw++) run_sweep(-1, 1'b0);
    check_slot("wrap", 0, 32'h2BFFFED4);
    check_slot("wrap", 31, 32'h2BFFFED4);
  endtask

  task automatic test_derived();
    logic [5:0]  ix;
    logic [31:0] exp_ph;
    do_reset();
    pitch_mode      = 1;
    first_busy_cyc  = -1;
    first_valid_cyc = -1;
    run_sweep(-1, 1'b0);
    check_counts("derived", 32, 1);
    n_cmp++;
    if (first_valid_cyc - first_busy_cyc != PITCH_LAT + 1) begin
      n_mis++;
      $display("FAIL latency: got %0d expected %0d", first_valid_cyc - first_busy_cyc, PITCH_LAT + 1);
    end
    for (int s = 0; s < SLOTS; s++) begin
      ix     = 6'(2 * s);
      exp_ph = {8'h00, ix, 18'h0};
      check_slot("derived", s, exp_ph);
    end
    pitch_mode = 0;
  endtask

  task automatic test_key_sync();
    do_reset();
    pitch_mode  = 0;
    pitch_const = 24'h000100;
    run_sweep(-1, 1'b0);
    run_sweep(-1, 1'b0);
    note_on     = 1'b1;
    cur_key_adr = 3'd5;
    m_flag[5]   = 1'b1;
    repeat (5) step();
    note_on = 1'b0;
    repeat (3) step();
    cur_key_adr = 3'd0;
    run_sweep(-1, 1'b0);
    check_counts("keysync", 32, 1);
    for (int s = 0; s < SLOTS; s++)
      check_slot("keysync_a", s, (s >= 20 && s <= 23) ? 32'h0 : 32'h300);
    run_sweep(-1, 1'b0);
    for (int s = 0; s < SLOTS; s++)
      check_slot("keysync_b", s, (s >= 20 && s <= 23) ? 32'h100 : 32'h400);
  endtask

  task automatic test_overrun();
    do_reset();
    pitch_mode  = 0;
    pitch_const = 24'h000100;
    run_sweep(10, 1'b0);
    check_counts("overrun", 32, 1);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_mis++;
      $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
    run_sweep(-1, 1'b1);
    check_counts("last_drain_tick", 32, 1);
    repeat (20) step();
    n_cmp++;
    if (overrun !== 1'b1 || sweep_busy !== 1'b0) begin
      n_mis++;
      $display("FAIL overrun_hold: got ovr=%b busy=%b expected ovr=1 busy=0", overrun, sweep_busy);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    pitch_mode  = 0;
    pitch_const = 24'h000100;
    run_sweep(10, 1'b0);
    sample_tick = 1'b1;
    step();
    k = 0;
    while (m_idx != 6'd30 && k < 100) begin
      step();
      k++;
    end
    do_reset();
    repeat (10) step();
    run_sweep(-1, 1'b0);
    check_counts("reset_mid", 32, 1);
    for (int s = 0; s < SLOTS; s++) check_slot("reset_mid", s, 32'h100);
  endtask

  initial begin
    n_cmp           = 0;
    n_mis           = 0;
    cyc             = 0;
    first_busy_cyc  = -1;
    first_valid_cyc = -1;
    sample_tick     = 1'b0;
    note_on         = 1'b0;
    cur_key_adr     = 3'd0;
    osc_pitch_val   = 24'h0;
    pitch_mode      = 0;
    pitch_const     = 24'h0;
    test_reset();
    test_basic();
    test_derived();
    test_key_sync();
    test_overrun();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
